// File: rtl/fixed_pkg.sv
// Shared fixed-point arithmetic definitions used by the divider and the multiplier.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FIXED_WIDTH = 16;
  localparam int FIXED_FRAC  = 15;

  // All-ones value of width w, used as the saturated quotient.
  function automatic logic [63:0] sat_ones(input int w);
    sat_ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a numerator bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             num_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The partial remainder is always below the divisor, so a kept difference
  // or a restored value both fit back into WIDTH bits.
  always_comb begin
    shifted = {rem_in, num_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_divider.sv
// Sequential unsigned Q-format divider, restoring algorithm, one quotient bit per cycle.
module fixed_divider
  import fixed_pkg::*;
#(
  parameter int WIDTH = FIXED_WIDTH,
  parameter int FRAC  = FIXED_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [63:0]      SAT_FULL = sat_ones(WIDTH);
  localparam logic [WIDTH-1:0] SAT      = SAT_FULL[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     num_q, num_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .num_bit (num_q[N-1]),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d      = N'(dividend) << FRAC;
          dvs_d      = divisor;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CW'(N);
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = SAT;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        num_d = num_q << 1;
        rem_d = step_rem;
        quo_d = N'({quo_q, step_bit});
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          remainder_d = step_rem;
          // Integer part beyond WIDTH-FRAC bits cannot be represented: saturate.
          if (quo_d[N-1 -: FRAC] != '0) begin
            quotient_d = SAT;
            overflow_d = 1'b1;
          end else begin
            quotient_d = quo_d[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: arithmetic reference model plus directed vectors.
module tb_fixed_divider;

  localparam int W = 16;
  localparam int F = 15;
  localparam int N = W + F;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;
  exp_t exp_fifo[$];

  fixed_divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    logic [63:0] num, q;
    num = 64'(dd) << F;
    if (dv == '0) begin
      e = '{q: '1, r: dd, dz: 1'b1, ov: 1'b0};
    end else begin
      q = num / 64'(dv);
      e.r  = W'(num % 64'(dv));
      e.dz = 1'b0;
      e.ov = ((q >> W) != 64'd0);
      e.q  = e.ov ? '1 : W'(q);
    end
    return e;
  endfunction

  // Track accepted transfers and consumed results at the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_fifo.delete();
    end else begin
      if (out_valid && out_ready && exp_fifo.size() > 0) void'(exp_fifo.pop_front());
      if (in_valid && in_ready) exp_fifo.push_back(model(dividend, divisor));
    end
  end

  // Compare DUT against the model on every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      check("handshake_exclusive", 64'(in_ready & out_valid), 64'd0);
      if (out_valid) begin
        if (exp_fifo.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          check("model_quotient",  64'(quotient),  64'(exp_fifo[0].q));
          check("model_remainder", 64'(remainder), 64'(exp_fifo[0].r));
          check("model_div_zero",  64'(div_zero),  64'(exp_fifo[0].dz));
          check("model_overflow",  64'(overflow),  64'(exp_fifo[0].ov));
        end
      end
    end
  end

  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input exp_t lit,
                        input int exp_edges, input int hold);
    int n;
    int edges;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    e = model(dd, dv);
    check("model_vs_literal", 64'(e), 64'(lit));
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    check("latency", 64'(edges), 64'(exp_edges));
    check("result_literal", 64'({quotient, remainder, div_zero, overflow}), 64'(lit));
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_quotient", 64'(quotient), 64'(lit.q));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_consume", 64'({in_ready, out_valid}), 64'b10);
  endtask

  task automatic check_cleared(input string name);
    check(name, 64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_cleared("reset_state");

    do_div(16'h4000, 16'h8000, '{q: 16'h4000, r: 16'h0000, dz: 1'b0, ov: 1'b0}, N, 0);
    do_div(16'h0001, 16'h0003, '{q: 16'h2AAA, r: 16'h0002, dz: 1'b0, ov: 1'b0}, N, 0);
    do_div(16'h0003, 16'h8000, '{q: 16'h0003, r: 16'h0000, dz: 1'b0, ov: 1'b0}, N, 0);
    do_div(16'h8000, 16'h4000, '{q: 16'hFFFF, r: 16'h0000, dz: 1'b0, ov: 1'b1}, N, 0);
    do_div(16'h1234, 16'h0000, '{q: 16'hFFFF, r: 16'h1234, dz: 1'b1, ov: 1'b0}, 0, 0);
    do_div(16'hFFFF, 16'h0001, '{q: 16'hFFFF, r: 16'h0000, dz: 1'b0, ov: 1'b1}, N, 0);
    do_div(16'h7FFF, 16'hFFFF, '{q: 16'h3FFF, r: 16'hBFFF, dz: 1'b0, ov: 1'b0}, N, 0);

    // Back-pressure, then an immediate follow-up transfer.
    do_div(16'h4000, 16'h8000, '{q: 16'h4000, r: 16'h0000, dz: 1'b0, ov: 1'b0}, N, 10);
    do_div(16'h0001, 16'h0003, '{q: 16'h2AAA, r: 16'h0002, dz: 1'b0, ov: 1'b0}, N, 0);

    // Reset during the calculation aborts it.
    dividend = 16'h4000;
    divisor  = 16'h8000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_cleared("reset_mid_calc");
    repeat (40) begin
      @(posedge clk); #1;
      check("no_valid_after_abort", 64'(out_valid), 64'd0);
    end
    do_div(16'h0003, 16'h8000, '{q: 16'h0003, r: 16'h0000, dz: 1'b0, ov: 1'b0}, N, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
